sample_frontend: RTL and testbench

Conditions raw codec samples into one stable input frame per sample period for the network forward pass. Runs on a single fast clock: it captures the four codec channels on a one-cycle `sample_strobe`, applies the `>>>2` input scaling, debounces jack detect, and substitutes the "unplugged" embed value on unplugged channels. It then issues a one-cycle `start` to the network and holds the frame until the network reports `done`. Strobes that arrive while a pass is in flight are dropped and counted as overruns.

---
 rtl/frontend_pkg.sv | 14 +
 rtl/jack_debounce.sv | 47 ++++
 rtl/sample_frontend.sv | 125 ++++++++++++
 tb/tb_sample_frontend.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frontend_pkg.sv
// Shared constants for the sample front end: FSM encodings and parameter defaults.
package frontend_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_BUSY  = 2'd2;

    localparam int W_DEFAULT             = 16;
    localparam int JACK_DEBOUNCE_DEFAULT = 4;
    localparam int UNPLUGGED_DEFAULT     = -32000;

endpackage

// File: rtl/jack_debounce.sv
// Strobe-paced debounce for one jack-detect bit; state_next exposes the
// post-update value so a frame captured on the same strobe sees a flip.
module jack_debounce #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic raw,
    output logic state,
    output logic state_next
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (en) begin
            if (raw != state) begin
                // Flip on the strobe that would bring the count up to N.
                if (cnt == CW'(N - 1)) begin
                    state_next = ~state;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end else begin
                cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: rtl/sample_frontend.sv
// Captures four scaled codec channels per sample strobe, hands the frame to the
// network with a start pulse, and counts strobes dropped while a pass runs.
module sample_frontend
    import frontend_pkg::*;
#(
    parameter int W             = W_DEFAULT,
    parameter int JACK_DEBOUNCE = JACK_DEBOUNCE_DEFAULT,
    parameter int UNPLUGGED     = UNPLUGGED_DEFAULT,
    parameter bit USE_IN3       = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_strobe,
    input  logic signed [W-1:0] sample_in0,
    input  logic signed [W-1:0] sample_in1,
    input  logic signed [W-1:0] sample_in2,
    input  logic signed [W-1:0] sample_in3,
    input  logic [7:0]          jack,
    input  logic                done,
    output logic signed [W-1:0] frame0,
    output logic signed [W-1:0] frame1,
    output logic signed [W-1:0] frame2,
    output logic signed [W-1:0] frame3,
    output logic                start,
    output logic                busy,
    output logic [3:0]          jack_state,
    output logic [15:0]         overrun_count
);

    localparam logic signed [W-1:0] UNPLUGGED_VAL = W'(UNPLUGGED);

    state_t              state;
    state_t              state_d;
    logic                capture;
    logic                overrun;
    logic [3:0]          jack_next;
    logic signed [W-1:0] sample  [4];
    logic signed [W-1:0] frame_d [4];
    logic signed [W-1:0] frame_q [4];
    logic                unused_jack_hi;

    assign unused_jack_hi = ^jack[7:4];

    assign sample[0] = sample_in0;
    assign sample[1] = sample_in1;
    assign sample[2] = sample_in2;
    assign sample[3] = sample_in3;

    // Debounce advances on every strobe, including ones the FSM drops.
    for (genvar i = 0; i < 4; i++) begin : g_jack
        jack_debounce #(.N(JACK_DEBOUNCE)) u_debounce (
            .clk        (clk),
            .rst        (rst),
            .en         (sample_strobe),
            .raw        (jack[i]),
            .state      (jack_state[i]),
            .state_next (jack_next[i])
        );
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            frame_d[i] = jack_next[i] ? (sample[i] >>> 2) : UNPLUGGED_VAL;
        end
        if (!USE_IN3) begin
            frame_d[3] = '0;
        end
    end

    always_comb begin
        state_d = state;
        capture = 1'b0;
        overrun = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample_strobe) begin
                    capture = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_BUSY;
                overrun = sample_strobe;
            end
            ST_BUSY: begin
                // A strobe landing with done chains straight into the next pass.
                if (done) begin
                    capture = sample_strobe;
                    state_d = sample_strobe ? ST_START : ST_IDLE;
                end else begin
                    overrun = sample_strobe;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            overrun_count <= '0;
            for (int i = 0; i < 4; i++) begin
                frame_q[i] <= '0;
            end
        end else begin
            state <= state_d;
            if (capture) begin
                for (int i = 0; i < 4; i++) begin
                    frame_q[i] <= frame_d[i];
                end
            end
            if (overrun && overrun_count != 16'hFFFF) begin
                overrun_count <= overrun_count + 16'd1;
            end
        end
    end

    assign frame0 = frame_q[0];
    assign frame1 = frame_q[1];
    assign frame2 = frame_q[2];
    assign frame3 = frame_q[3];
    assign start  = (state == ST_START);
    assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_sample_frontend.sv
// Directed bench for sample_frontend: stimulus queues expected frames, a
// monitor pops and compares them whenever start is seen.
module tb_sample_frontend;

    logic               clk;
    logic               rst;
    logic               sample_strobe;
    logic signed [15:0] sample_in0, sample_in1, sample_in2, sample_in3;
    logic [7:0]         jack;
    logic               done;
    logic signed [15:0] frame0, frame1, frame2, frame3;
    logic               start;
    logic               busy;
    logic [3:0]         jack_state;
    logic [15:0]        overrun_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         f0;
        int         f1;
        int         f2;
        int         f3;
        logic [3:0] js;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_start = 1'b0;

    localparam int UNP = -32000;

    sample_frontend dut (
        .clk           (clk),
        .rst           (rst),
        .sample_strobe (sample_strobe),
        .sample_in0    (sample_in0),
        .sample_in1    (sample_in1),
        .sample_in2    (sample_in2),
        .sample_in3    (sample_in3),
        .jack          (jack),
        .done          (done),
        .frame0        (frame0),
        .frame1        (frame1),
        .frame2        (frame2),
        .frame3        (frame3),
        .start         (start),
        .busy          (busy),
        .jack_state    (jack_state),
        .overrun_count (overrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input int f0, input int f1, input int f2, input int f3,
                                input logic [3:0] js);
        exp_t e;
        e.f0 = f0; e.f1 = f1; e.f2 = f2; e.f3 = f3; e.js = js;
        exp_q.push_back(e);
    endtask

    task automatic set_samples(input int a0, input int a1, input int a2, input int a3);
        sample_in0 = 16'(a0);
        sample_in1 = 16'(a1);
        sample_in2 = 16'(a2);
        sample_in3 = 16'(a3);
    endtask

    task automatic strobe(input int a0, input int a1, input int a2, input int a3);
        set_samples(a0, a1, a2, a3);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    // Called in the START cycle: move to BUSY, return done, land in IDLE.
    task automatic finish_pass();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && start) begin
            chk("start_single_pulse", int'(prev_start), 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_start: start seen with no capture expected");
            end else begin
                mon_e = exp_q.pop_front();
                chk("frame0", int'(frame0), mon_e.f0);
                chk("frame1", int'(frame1), mon_e.f1);
                chk("frame2", int'(frame2), mon_e.f2);
                chk("frame3", int'(frame3), mon_e.f3);
                chk("jack_state_at_start", int'(jack_state), int'(mon_e.js));
            end
        end
        prev_start = start;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        sample_strobe = 1'b0;
        set_samples(0, 0, 0, 0);
        jack = 8'h00;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset values
        chk("rst_frame0", int'(frame0), 0);
        chk("rst_start", int'(start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_jack_state", int'(jack_state), 0);
        chk("rst_overrun", int'(overrun_count), 0);

        // done in IDLE is ignored
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("idle_done_busy", int'(busy), 0);

        // Debounce from reset: channel 0 plugged, flips on the 4th strobe
        jack = 8'h01;
        for (int k = 0; k < 3; k++) begin
            expect_frame(UNP, UNP, UNP, 0, 4'b0000);
            strobe(16'h0100, 0, 0, 0);
            finish_pass();
        end
        expect_frame(16'h0040, UNP, UNP, 0, 4'b0001);
        strobe(16'h0100, 0, 0, 0);
        finish_pass();

        // Three short drops must not unplug channel 0
        jack = 8'h00;
        for (int k = 0; k < 3; k++) begin
            expect_frame(-2, UNP, UNP, 0, 4'b0001);
            strobe(-5, 0, 0, 0);
            chk("glitch_jack0_held", int'(jack_state[0]), 1);
            finish_pass();
        end

        // Plug all; channels 1..3 debounce on the 4th strobe
        jack = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            expect_frame(16'h0080, UNP, UNP, 0, 4'b0001);
            strobe(16'h0200, 16'h0400, 16'h0800, 16'h0C00);
            finish_pass();
        end

        // Scale and sign, done five cycles after the strobe
        expect_frame(16'h0400, -2, 16'h1FFF, 0, 4'b1111);
        strobe(16'h1000, -5, 16'h7FFF, 16'h1234);
        chk("scale_start_t1", int'(start), 1);
        chk("scale_busy_t1", int'(busy), 1);
        tick();
        chk("scale_start_t2", int'(start), 0);
        tick();
        tick();
        tick();
        chk("scale_busy_before_done", int'(busy), 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("scale_busy_after_done", int'(busy), 0);

        // Overrun: strobe in START and in BUSY, no done
        expect_frame(4, 8, -16, 0, 4'b1111);
        strobe(16'h0010, 16'h0020, -64, 16'h0007);
        strobe(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        strobe(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        chk("overrun_count_2", int'(overrun_count), 2);
        chk("overrun_frame0", int'(frame0), 4);
        chk("overrun_frame2", int'(frame2), -16);
        chk("overrun_busy", int'(busy), 1);
        finish_pass();

        // done and strobe together in BUSY chain into a new pass
        expect_frame(16'h0100, 16'h0200, 16'h0300, 0, 4'b1111);
        strobe(16'h0400, 16'h0800, 16'h0C00, 16'h1000);
        tick();
        expect_frame(-1, -3, 16'h0001, 0, 4'b1111);
        set_samples(-1, -9, 16'h0004, 16'h0008);
        done = 1'b1;
        sample_strobe = 1'b1;
        tick();
        done = 1'b0;
        sample_strobe = 1'b0;
        chk("coincident_start", int'(start), 1);
        chk("coincident_overrun", int'(overrun_count), 2);
        finish_pass();

        // Reset mid-pass with a coincident strobe
        expect_frame(16'h0010, 16'h0010, 16'h0010, 0, 4'b1111);
        strobe(16'h0040, 16'h0040, 16'h0040, 16'h0040);
        tick();
        rst = 1'b1;
        set_samples(16'h7000, 16'h7000, 16'h7000, 16'h7000);
        sample_strobe = 1'b1;
        tick();
        rst = 1'b0;
        sample_strobe = 1'b0;
        chk("midrst_frame0", int'(frame0), 0);
        chk("midrst_frame1", int'(frame1), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_start", int'(start), 0);
        chk("midrst_jack_state", int'(jack_state), 0);
        chk("midrst_overrun", int'(overrun_count), 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("midrst_late_done_busy", int'(busy), 0);
        expect_frame(UNP, UNP, UNP, 0, 4'b0000);
        strobe(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        chk("midrst_next_busy", int'(busy), 1);
        finish_pass();

        // Saturation: hold strobe high through START and BUSY
        expect_frame(UNP, UNP, UNP, 0, 4'b0000);
        strobe(16'h0020, 16'h0020, 16'h0020, 16'h0020);
        sample_strobe = 1'b1;
        repeat (100) tick();
        chk("sat_partial", int'(overrun_count), 100);
        repeat (65437) tick();
        sample_strobe = 1'b0;
        chk("sat_full", int'(overrun_count), 16'hFFFF);
        chk("sat_frame0_held", int'(frame0), UNP);
        finish_pass();
        tick();

        chk("all_starts_seen", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
